lsu_mem_port: RTL and testbench

- Load/store initiator between the CPU core and the synchronous word RAM.
- The RAM has a byte address with the low 2 bits ignored, a 1-cycle registered read, and whole-word writes.
- Turns core byte/half/word load and store requests into RAM word accesses.
- Loads get lane extraction with sign/zero extension; sub-word stores use read-modify-write; alignment is checked.

---
 rtl/lsu_mem_port.sv | 159 +++++++++++++++
 tb/tb_lsu_mem_port.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_port.sv
// lsu_mem_port: turns core byte/half/word loads and stores into word accesses on a 1-cycle synchronous RAM.
// Define LSU_ALIGN_CHECK_EN to report misaligned/illegal requests via resp_err; otherwise they are force-aligned.
module lsu_mem_port #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_wen,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {IDLE, RD, RD_WAIT, RMW_RD, RMW_MRG, WR, ERR} state_t;

  state_t      state;
  logic [1:0]  op_size;
  logic        op_unsigned;
  logic [1:0]  op_lane;
  logic [15:0] op_wdata;

  logic [1:0]  acc_size;
  logic [1:0]  acc_lane;
`ifdef LSU_ALIGN_CHECK_EN
  logic        acc_err;
`endif

  assign req_ready = (state == IDLE);

  // Request decode: either flag bad alignment/size or coerce the request into a legal one.
  always_comb begin
    acc_size = req_size;
    acc_lane = req_addr[1:0];
`ifdef LSU_ALIGN_CHECK_EN
    acc_err  = (req_size == 2'b11) ||
               ((req_size == SZ_HALF) && req_addr[0]) ||
               ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
    if (req_size == 2'b11) acc_size = SZ_WORD;
    if (acc_size == SZ_HALF)      acc_lane[0] = 1'b0;
    else if (acc_size == SZ_WORD) acc_lane    = 2'b00;
`endif
  end

  // Little-endian lane extraction with sign/zero extension.
  function automatic logic [DATA_WIDTH-1:0] load_extend(input logic [DATA_WIDTH-1:0] w,
                                                        input logic [1:0] sz,
                                                        input logic uns,
                                                        input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lane, 3'b000} +: 8];
    h = w[{lane[1], 4'b0000} +: 16];
    case (sz)
      SZ_BYTE: load_extend = {{(DATA_WIDTH-8){b[7] & ~uns}}, b};
      SZ_HALF: load_extend = {{(DATA_WIDTH-16){h[15] & ~uns}}, h};
      default: load_extend = w;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] store_merge(input logic [DATA_WIDTH-1:0] w,
                                                        input logic [1:0] sz,
                                                        input logic [1:0] lane,
                                                        input logic [15:0] d);
    store_merge = w;
    if (sz == SZ_BYTE) store_merge[{lane, 3'b000} +: 8]     = d[7:0];
    else               store_merge[{lane[1], 4'b0000} +: 16] = d;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      op_size     <= '0;
      op_unsigned <= 1'b0;
      op_lane     <= '0;
      op_wdata    <= '0;
      resp_valid  <= 1'b0;
      resp_rdata  <= '0;
`ifdef LSU_ALIGN_CHECK_EN
      resp_err    <= 1'b0;
`endif
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_wen     <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      mem_wen    <= 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
      resp_err   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_size     <= acc_size;
            op_unsigned <= req_unsigned;
            op_lane     <= acc_lane;
            op_wdata    <= req_wdata[15:0];
            mem_addr    <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
`ifdef LSU_ALIGN_CHECK_EN
            if (acc_err) state <= ERR;
            else
`endif
            if (!req_we) state <= RD;
            else if (acc_size == SZ_WORD) begin
              state     <= WR;
              mem_wen   <= 1'b1;
              mem_wdata <= req_wdata;
            end else state <= RMW_RD;
          end
        end
        RD:      state <= RD_WAIT;
        RD_WAIT: begin
          resp_rdata <= load_extend(mem_rdata, op_size, op_unsigned, op_lane);
          resp_valid <= 1'b1;
          state      <= IDLE;
        end
        RMW_RD:  state <= RMW_MRG;
        RMW_MRG: begin
          mem_wdata <= store_merge(mem_rdata, op_size, op_lane, op_wdata);
          mem_wen   <= 1'b1;
          state     <= WR;
        end
        WR: begin
          resp_valid <= 1'b1;
          state      <= IDLE;
        end
`ifdef LSU_ALIGN_CHECK_EN
        ERR: begin
          resp_valid <= 1'b1;
          resp_err   <= 1'b1;
          resp_rdata <= '0;
          state      <= IDLE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

`ifndef LSU_ALIGN_CHECK_EN
  assign resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_mem_port.sv
// Bench for lsu_mem_port: byte-array reference model, per-cycle compare, directed and random ops.
module tb_lsu_mem_port;
  localparam int unsigned AW     = 10;
  localparam int unsigned DW     = 32;
  localparam int unsigned NWORDS = 1 << (AW - 2);

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_we = 1'b0;
  logic [1:0]    req_size = 2'b00;
  logic          req_unsigned = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          req_ready, resp_valid, resp_err, mem_wen;
  logic [DW-1:0] resp_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  lsu_mem_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous word RAM with registered read.
  logic [DW-1:0] ram [NWORDS];
  logic [DW-1:0] ram_q;
  always @(posedge clk) begin
    if (mem_wen) ram[mem_addr[AW-1:2]] <= mem_wdata;
    ram_q <= ram[mem_addr[AW-1:2]];
  end
  assign mem_rdata = ram_q;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] ref_mem [1 << AW];

  typedef struct {
    int            due;
    bit            wen;
    int            wen_due;
    logic [DW-1:0] wword;
    logic [AW-1:0] waddr;
    bit            chk_data;
    logic [DW-1:0] rdata;
    bit            err;
  } exp_t;
  exp_t expq[$];

  int n_cmp = 0, n_bad = 0, n_resp = 0, n_wen = 0, last_resp_cyc = 0;
  logic [DW-1:0] last_rdata = '0;
  logic          last_err = 1'b0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired at cycle %0d", name, cyc);
  endtask

  // Reference: byte-addressed memory, expected response and write timing per accepted op.
  function automatic exp_t model(input bit we, input logic [1:0] sz, input bit uns,
                                 input logic [AW-1:0] a_in, input logic [DW-1:0] wd, input int acc);
    exp_t e;
    int nb, v;
    logic [AW-1:0] a, base;
    bit err;
    a   = a_in;
    err = 1'b0;
    nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
`ifdef LSU_ALIGN_CHECK_EN
    err = (sz == 2'd3) || ((int'(a) % nb) != 0);
`else
    a = AW'(int'(a) - (int'(a) % nb));
`endif
    base       = {a[AW-1:2], 2'b00};
    e.err      = err;
    e.wen      = 1'b0;
    e.wen_due  = -1;
    e.wword    = '0;
    e.waddr    = base;
    e.chk_data = !we || err;
    e.rdata    = '0;
    if (err) e.due = acc + 1;
    else if (!we) begin
      v = 0;
      for (int i = 0; i < nb; i++) v = v | (int'(ref_mem[AW'(int'(a) + i)]) << (8 * i));
      if (!uns && nb < 4 && v >= (1 << (8 * nb - 1))) v = v - (1 << (8 * nb));
      e.rdata = DW'(v);
      e.due   = acc + 2;
    end else begin
      for (int i = 0; i < nb; i++) ref_mem[AW'(int'(a) + i)] = wd[8*i +: 8];
      e.wen     = 1'b1;
      e.wword   = {ref_mem[base + 3], ref_mem[base + 2], ref_mem[base + 1], ref_mem[base]};
      e.due     = acc + ((nb == 4) ? 1 : 3);
      e.wen_due = e.due - 1;
    end
    return e;
  endfunction

  // Per-cycle compare against the head expectation.
  always @(negedge clk) begin
    exp_t e;
    bit ev, ew;
    if (!rst_n) begin
      check("rst_resp_valid", DW'(resp_valid), '0);
      check("rst_resp_err", DW'(resp_err), '0);
      check("rst_mem_wen", DW'(mem_wen), '0);
      check("rst_resp_rdata", resp_rdata, '0);
      check("rst_mem_addr", DW'(mem_addr), '0);
    end else begin
      ev = 1'b0;
      ew = 1'b0;
      if (expq.size() > 0) begin
        e  = expq[0];
        ev = (e.due == cyc);
        ew = e.wen && (e.wen_due == cyc);
      end
      check("resp_valid", DW'(resp_valid), DW'(ev));
      check("mem_wen", DW'(mem_wen), DW'(ew));
      check("mem_addr_align", DW'(mem_addr[1:0]), '0);
      if (mem_wen === 1'b1) n_wen++;
      if (ew) begin
        check("mem_wdata", mem_wdata, e.wword);
        check("mem_addr_wr", DW'(mem_addr), DW'(e.waddr));
      end
      if (ev) begin
        check("resp_err", DW'(resp_err), DW'(e.err));
        if (e.chk_data) check("resp_rdata", resp_rdata, e.rdata);
        void'(expq.pop_front());
        n_resp++;
        last_rdata    = resp_rdata;
        last_err      = resp_err;
        last_resp_cyc = cyc;
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue_op(input bit we, input logic [1:0] sz, input bit uns, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, input bit use_model, output int acc);
    int k;
    k = 0;
    while (!req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready) begin
      fail_timeout("ready_timeout");
      acc = -1;
      return;
    end
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = a;
    req_wdata    = wd;
    acc          = cyc + 1;
    if (use_model) expq.push_back(model(we, sz, uns, a, wd, acc));
    @(negedge clk);
    req_valid    = 1'b0;
    req_we       = 1'($urandom_range(0, 1));
    req_size     = 2'($urandom_range(0, 3));
    req_unsigned = 1'($urandom_range(0, 1));
    req_addr     = AW'($urandom);
    req_wdata    = $urandom;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (expq.size() > 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (expq.size() > 0) begin
      fail_timeout("resp_timeout");
      expq.delete();
    end
  endtask

  task automatic run_op(input bit we, input logic [1:0] sz, input bit uns, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, output int acc);
    issue_op(we, sz, uns, a, wd, 1'b1, acc);
    wait_idle();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] w;
    int acc, acc2, w0, r0;
    for (int i = 0; i < NWORDS; i++) begin
      w = $urandom;
      ram[i] = w;
      for (int j = 0; j < 4; j++) ref_mem[4*i + j] = w[8*j +: 8];
    end
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("reset_ready", DW'(req_ready), DW'(1));
    check("reset_resp_valid", DW'(resp_valid), '0);
    check("reset_mem_wen", DW'(mem_wen), '0);

    // Word store then word load.
    w0 = n_wen;
    run_op(1'b1, 2'd2, 1'b0, 10'h010, 32'hDEADBEEF, acc);
    check("t1_store_lat", DW'(last_resp_cyc - acc), DW'(1));
    check("t1_wen_once", DW'(n_wen - w0), DW'(1));
    run_op(1'b0, 2'd2, 1'b0, 10'h010, '0, acc);
    check("t1_load_data", last_rdata, 32'hDEADBEEF);
    check("t1_load_err", DW'(last_err), '0);
    check("t1_load_lat", DW'(last_resp_cyc - acc), DW'(2));

    // Byte store via read-modify-write.
    run_op(1'b1, 2'd2, 1'b0, 10'h010, 32'h11223344, acc);
    w0 = n_wen;
    run_op(1'b1, 2'd0, 1'b0, 10'h013, 32'h000000AA, acc);
    check("t2_rmw_lat", DW'(last_resp_cyc - acc), DW'(3));
    check("t2_wen_once", DW'(n_wen - w0), DW'(1));
    run_op(1'b0, 2'd2, 1'b0, 10'h010, '0, acc);
    check("t2_merged", last_rdata, 32'hAA223344);

    // Sub-word load extension.
    run_op(1'b1, 2'd2, 1'b0, 10'h020, 32'h80FF7F01, acc);
    run_op(1'b0, 2'd0, 1'b0, 10'h023, '0, acc);
    check("t3_byte_s", last_rdata, 32'hFFFFFF80);
    run_op(1'b0, 2'd0, 1'b1, 10'h023, '0, acc);
    check("t3_byte_u", last_rdata, 32'h00000080);
    run_op(1'b0, 2'd1, 1'b0, 10'h020, '0, acc);
    check("t3_half_lo", last_rdata, 32'h00007F01);
    run_op(1'b0, 2'd1, 1'b0, 10'h022, '0, acc);
    check("t3_half_hi", last_rdata, 32'hFFFF80FF);

    // Misaligned word load and half store.
    run_op(1'b1, 2'd2, 1'b0, 10'h014, 32'h55667788, acc);
    w0 = n_wen;
    run_op(1'b0, 2'd2, 1'b0, 10'h021, '0, acc);
`ifdef LSU_ALIGN_CHECK_EN
    check("t4_load_err", DW'(last_err), DW'(1));
    check("t4_load_rdata", last_rdata, '0);
`else
    check("t4_load_err", DW'(last_err), '0);
    check("t4_load_rdata", last_rdata, 32'h80FF7F01);
`endif
    run_op(1'b1, 2'd1, 1'b0, 10'h015, 32'h0000BEEF, acc);
`ifdef LSU_ALIGN_CHECK_EN
    check("t4_store_err", DW'(last_err), DW'(1));
    check("t4_no_wen", DW'(n_wen - w0), '0);
`else
    check("t4_store_err", DW'(last_err), '0);
    check("t4_one_wen", DW'(n_wen - w0), DW'(1));
`endif
    run_op(1'b0, 2'd2, 1'b0, 10'h014, '0, acc);
`ifdef LSU_ALIGN_CHECK_EN
    check("t4_ram_word", last_rdata, 32'h55667788);
`else
    check("t4_ram_word", last_rdata, 32'h5566BEEF);
`endif

    // Reset while the byte store is merging.
    run_op(1'b1, 2'd2, 1'b0, 10'h030, 32'hCAFEF00D, acc);
    r0 = n_resp;
    issue_op(1'b1, 2'd0, 1'b0, 10'h031, 32'h0000005A, 1'b0, acc);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t5_wen_low", DW'(mem_wen), '0);
    check("t5_no_resp", DW'(resp_valid), '0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("t5_ready", DW'(req_ready), DW'(1));
    check("t5_resp_count", DW'(n_resp - r0), '0);
    check("t5_ram_kept", ram[8'h0C], 32'hCAFEF00D);
    run_op(1'b0, 2'd2, 1'b0, 10'h030, '0, acc);
    check("t5_load", last_rdata, 32'hCAFEF00D);

    // Load accepted in the response cycle of a word store.
    r0 = n_resp;
    issue_op(1'b1, 2'd2, 1'b0, 10'h040, 32'h01020304, 1'b1, acc);
    issue_op(1'b0, 2'd2, 1'b0, 10'h040, '0, 1'b1, acc2);
    wait_idle();
    check("t6_b2b_gap", DW'(acc2 - acc), DW'(2));
    check("t6_resp_count", DW'(n_resp - r0), DW'(2));
    check("t6_load", last_rdata, 32'h01020304);

    // Random traffic, half of it concentrated on a few words.
    for (int n = 0; n < 400; n++) begin
      logic [AW-1:0] a;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      a = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 31)) : AW'($urandom);
      issue_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               a, $urandom, 1'b1, acc);
    end
    wait_idle();
    repeat (2) @(negedge clk);

    for (int i = 0; i < NWORDS; i++)
      check("ram_final", ram[i], {ref_mem[4*i + 3], ref_mem[4*i + 2], ref_mem[4*i + 1], ref_mem[4*i]});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
